// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM -> WB pipeline register with a one-entry skid buffer.
//
// Captures the write-back triple (enable, address, data) from the memory stage
// and holds it in a head register that drives the register-file write port.
// A valid/ready handshake plus a skid register lets the write-back side stall
// without ever dropping an instruction. ready_o comes only from the occupancy
// register, so there is no combinational path from ready_i to ready_o.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   valid_i / ready_o   upstream handshake (memory stage)
//   write_reg_*_i       incoming write-back triple
//   flush_i             synchronous flush; empties head and skid
//   ready_i / valid_o   downstream handshake (write-back side)
//   write_reg_*_o       head entry (enable is raw, registered)
//   wb_we_o             commit strobe to the register file (r0 suppressed)
//   retire_cnt_o        pop counter, present only with MEM_WB_RETIRE_CNT_EN
//
// Optional feature macro: MEM_WB_RETIRE_CNT_EN adds a 32-bit wrapping count of
// popped entries (not cleared by flush_i).
module mem_wb_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              write_reg_en_i,
  input  logic [ADDR_W-1:0] write_reg_addr_i,
  input  logic [DATA_W-1:0] write_reg_data_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              write_reg_en_o,
  output logic [ADDR_W-1:0] write_reg_addr_o,
  output logic [DATA_W-1:0] write_reg_data_o,
  output logic              wb_we_o
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt_o
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic              head_en_q, head_en_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              skid_en_q, skid_en_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic pop;

  assign valid_o          = (state_q != StEmpty);
  assign ready_o          = (state_q != StFull);
  assign write_reg_en_o   = head_en_q;
  assign write_reg_addr_o = head_addr_q;
  assign write_reg_data_o = head_data_q;

  assign accept  = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  // Commit uses the current head, so a pop in a flush cycle still writes.
  assign wb_we_o = pop & head_en_q & (head_addr_q != '0);

  always_comb begin
    state_d     = state_q;
    head_en_d   = head_en_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    skid_en_d   = skid_en_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;

    if (flush_i) begin
      // Anything accepted this cycle is discarded along with the queue.
      state_d   = StEmpty;
      head_en_d = 1'b0;
      skid_en_d = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_en_d   = write_reg_en_i;
            head_addr_d = write_reg_addr_i;
            head_data_d = write_reg_data_i;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_en_d   = write_reg_en_i;
            head_addr_d = write_reg_addr_i;
            head_data_d = write_reg_data_i;
          end else if (accept) begin
            skid_en_d   = write_reg_en_i;
            skid_addr_d = write_reg_addr_i;
            skid_data_d = write_reg_data_i;
            state_d     = StFull;
          end else if (pop) begin
            head_en_d = 1'b0;
            state_d   = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_en_d   = skid_en_q;
            head_addr_d = skid_addr_q;
            head_data_d = skid_data_q;
            skid_en_d   = 1'b0;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      head_en_q   <= 1'b0;
      head_addr_q <= '0;
      head_data_q <= '0;
      skid_en_q   <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      head_en_q   <= head_en_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      skid_en_q   <= skid_en_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  assign retire_cnt_o = retire_cnt_q;

  // Counts every pop, bubbles included; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else if (pop) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic              ready_o;
  logic              write_reg_en_i;
  logic [ADDR_W-1:0] write_reg_addr_i;
  logic [DATA_W-1:0] write_reg_data_i;
  logic              flush_i;
  logic              ready_i;
  logic              valid_o;
  logic              write_reg_en_o;
  logic [ADDR_W-1:0] write_reg_addr_o;
  logic [DATA_W-1:0] write_reg_data_o;
  logic              wb_we_o;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0]       retire_cnt_o;
`endif

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .write_reg_en_i   (write_reg_en_i),
    .write_reg_addr_i (write_reg_addr_i),
    .write_reg_data_i (write_reg_data_i),
    .flush_i          (flush_i),
    .ready_i          (ready_i),
    .valid_o          (valid_o),
    .write_reg_en_o   (write_reg_en_o),
    .write_reg_addr_o (write_reg_addr_o),
    .write_reg_data_o (write_reg_data_o),
    .wb_we_o          (wb_we_o)
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o     (retire_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs for one cycle, the commit strobe expected in that cycle (before the
  // edge) and the registered outputs expected after the edge.
  typedef struct {
    logic        valid;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        flush;
    logic        rdy;
    logic        exp_we;
    logic        exp_valid;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[16];

  task automatic drive(input logic v, input logic en, input logic [4:0] a,
                       input logic [31:0] d, input logic fl, input logic r);
    valid_i          = v;
    write_reg_en_i   = en;
    write_reg_addr_i = a;
    write_reg_data_i = d;
    flush_i          = fl;
    ready_i          = r;
  endtask

  initial begin
    //             vld en addr data          fl rdy | we  v  en addr data          rdy
    // streaming
    vecs[0]  = '{1, 1, 5,  32'h1234_5678, 0, 1,  0,  1, 1, 5,  32'h1234_5678, 1};
    vecs[1]  = '{1, 1, 6,  32'hDEAD_BEEF, 0, 1,  1,  1, 1, 6,  32'hDEAD_BEEF, 1};
    vecs[2]  = '{0, 0, 0,  32'h0,         0, 1,  1,  0, 0, 6,  32'hDEAD_BEEF, 1};
    // backpressure: A=3, B=4, C offered while full must be ignored
    vecs[3]  = '{1, 1, 3,  32'h0000_0033, 0, 0,  0,  1, 1, 3,  32'h0000_0033, 1};
    vecs[4]  = '{1, 1, 4,  32'h0000_0044, 0, 0,  0,  1, 1, 3,  32'h0000_0033, 0};
    vecs[5]  = '{1, 1, 7,  32'h0000_0077, 0, 1,  1,  1, 1, 4,  32'h0000_0044, 1};
    vecs[6]  = '{0, 0, 0,  32'h0,         0, 1,  1,  0, 0, 4,  32'h0000_0044, 1};
    // r0 suppression
    vecs[7]  = '{1, 1, 0,  32'hFFFF_FFFF, 0, 1,  0,  1, 1, 0,  32'hFFFF_FFFF, 1};
    vecs[8]  = '{0, 0, 0,  32'h0,         0, 1,  0,  0, 0, 0,  32'hFFFF_FFFF, 1};
    // bubble (en=0) occupies an entry and pops without a write
    vecs[9]  = '{1, 0, 9,  32'h0000_0099, 0, 0,  0,  1, 0, 9,  32'h0000_0099, 1};
    vecs[10] = '{0, 0, 0,  32'h0,         0, 1,  0,  0, 0, 9,  32'h0000_0099, 1};
    // flush collision in FULL with ready_i=1: head commits, skid lost
    vecs[11] = '{1, 1, 10, 32'h0000_000A, 0, 0,  0,  1, 1, 10, 32'h0000_000A, 1};
    vecs[12] = '{1, 1, 11, 32'h0000_000B, 0, 0,  0,  1, 1, 10, 32'h0000_000A, 0};
    vecs[13] = '{0, 0, 0,  32'h0,         1, 1,  1,  0, 0, 10, 32'h0000_000A, 1};
    vecs[14] = '{1, 1, 12, 32'h0000_000C, 0, 1,  0,  1, 1, 12, 32'h0000_000C, 1};
    // flush wins over a same-cycle accept
    vecs[15] = '{1, 1, 13, 32'h0000_000D, 1, 0,  0,  0, 0, 12, 32'h0000_000C, 1};

    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid_o", {31'd0, valid_o}, 32'd0);
    check("reset en_o",    {31'd0, write_reg_en_o}, 32'd0);
    check("reset addr_o",  {27'd0, write_reg_addr_o}, 32'd0);
    check("reset data_o",  write_reg_data_o, 32'd0);
    check("reset ready_o", {31'd0, ready_o}, 32'd1);
    check("reset wb_we_o", {31'd0, wb_we_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].flush, vecs[i].rdy);
      #1;
      check($sformatf("v%0d wb_we_o", i), {31'd0, wb_we_o}, {31'd0, vecs[i].exp_we});
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid_o", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d en_o", i), {31'd0, write_reg_en_o}, {31'd0, vecs[i].exp_en});
      check($sformatf("v%0d addr_o", i), {27'd0, write_reg_addr_o}, {27'd0, vecs[i].exp_addr});
      check($sformatf("v%0d data_o", i), write_reg_data_o, vecs[i].exp_data);
      check($sformatf("v%0d ready_o", i), {31'd0, ready_o}, {31'd0, vecs[i].exp_ready});
    end
    drive(0, 0, 0, 0, 0, 0);

`ifdef MEM_WB_RETIRE_CNT_EN
    // pops in v1,v2,v5,v6,v8,v10,v13
    check("retire count after table", retire_cnt_o, 32'd7);
`endif

    // Fill to FULL, then show ready_o does not follow ready_i combinationally.
    @(posedge clk);
    #1;
    drive(1, 1, 20, 32'hAAAA_0001, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 1, 21, 32'hAAAA_0002, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("full ready_o with ready_i=1", {31'd0, ready_o}, 32'd0);
    check("full head addr", {27'd0, write_reg_addr_o}, 32'd20);
    ready_i = 1'b0;
    #1;

`ifdef MEM_WB_RETIRE_CNT_EN
    // Flush with two entries queued and no pop: count unchanged.
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush valid_o", {31'd0, valid_o}, 32'd0);
    check("retire count after flush", retire_cnt_o, 32'd7);
    drive(1, 1, 20, 32'hAAAA_0001, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 1, 21, 32'hAAAA_0002, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
`endif

    // Asynchronous reset mid-cycle while FULL.
    #2;
    rst = 1'b0;
    #1;
    check("async rst valid_o", {31'd0, valid_o}, 32'd0);
    check("async rst en_o",    {31'd0, write_reg_en_o}, 32'd0);
    check("async rst addr_o",  {27'd0, write_reg_addr_o}, 32'd0);
    check("async rst data_o",  write_reg_data_o, 32'd0);
    check("async rst ready_o", {31'd0, ready_o}, 32'd1);
`ifdef MEM_WB_RETIRE_CNT_EN
    check("async rst retire count", retire_cnt_o, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("post rst valid_o", {31'd0, valid_o}, 32'd0);
    check("post rst wb_we_o", {31'd0, wb_we_o}, 32'd0);

    // One more push/pop after reset: skid content must be gone.
    drive(1, 1, 2, 32'h0BAD_F00D, 0, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("post rst wb_we_o push", {31'd0, wb_we_o}, 32'd1);
    check("post rst addr_o", {27'd0, write_reg_addr_o}, 32'd2);
    @(posedge clk);
    #1;
    check("post rst drained", {31'd0, valid_o}, 32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
    check("retire count single pop", retire_cnt_o, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- Pipeline register between the memory-access stage and the register-file write port of the 5-stage pipeline.
- Captures the write-back triple (enable, address, data) from the memory stage and presents it to the register file.
- Uses a valid/ready handshake with a one-entry skid buffer, so backpressure from the write-back side never drops an instruction.
- Flush empties both entries; writes to register 0 are suppressed at the commit point.

Parameters:
- DATA_W, 32, width of write-back data.
- ADDR_W, 5, width of register address.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-low reset.
- valid_i  input  1  memory stage presents a valid write-back triple.
- ready_o  output  1  block can accept a triple this cycle.
- write_reg_en_i  input  1  instruction writes a register.
- write_reg_addr_i  input  ADDR_W  destination register.
- write_reg_data_i  input  DATA_W  write-back value.
- flush_i  input  1  synchronous flush from control unit.
- ready_i  input  1  write-back side accepts the head entry (low = stall).
- valid_o  output  1  head entry valid.
- write_reg_en_o  output  1  head entry write enable (raw, registered).
- write_reg_addr_o  output  ADDR_W  head entry address.
- write_reg_data_o  output  DATA_W  head entry data.
- wb_we_o  output  1  commit strobe to the register file.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Storage: head register (drives the *_o ports) plus skid register.
- Occupancy states: EMPTY (0), ONE (head only), FULL (head plus skid).
- Reset: state EMPTY, valid_o=0, write_reg_en_o=0, write_reg_addr_o=0, write_reg_data_o=0, skid cleared, ready_o=1.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- accept = valid_i & ready_o.
- pop = valid_o & ready_i.
- ready_o is registered: ready_o = (state != FULL). Combinational path from ready_i to ready_o is forbidden.
- EMPTY:
  - accept -> load head, go to ONE.
  - Latency input to valid_o: 1 cycle.
- ONE:
  - accept & pop -> head reloads from input, stay in ONE.
  - accept & !pop -> input goes to skid, go to FULL.
  - !accept & pop -> go to EMPTY.
  - Otherwise hold.
- FULL:
  - pop -> skid moves to head, go to ONE.
  - Otherwise hold.
  - No accept is possible, since ready_o=0.
- Order is strictly FIFO; the skid entry never overtakes the head.
- wb_we_o = valid_o & ready_i & write_reg_en_o & (write_reg_addr_o != 0). Purely combinational.
- Address 0 commits pop normally but never asserts wb_we_o.
- Triples with write_reg_en_i=0 still occupy an entry and pop normally (bubble/no-write instructions).
- flush_i (highest priority):
  - Next state EMPTY; valid_o, write_reg_en_o and the skid valid cleared.
  - Input accepted in the same cycle is discarded.
  - A pop in the same cycle still commits (wb_we_o is computed from the current head).
- When valid_o=0, the head data/address hold their last values; only valid_o and write_reg_en_o are guaranteed 0.
- Widths are exact; no arithmetic is performed on the data path.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt_o [31:0].
  - Counter increments by 1 on every pop, including no-write entries, and wraps 0xFFFFFFFF -> 0.
  - Reset to 0; not cleared by flush_i.
  - Flush-discarded entries are never counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle with state FULL -> immediately valid_o=0, write_reg_en_o=0, addr=0, data=0, ready_o=1.
- Streaming: ready_i=1; push (en=1, addr=5, data=0x1234_5678), then (en=1, addr=6, data=0xDEAD_BEEF) back-to-back -> wb_we_o pulses on consecutive cycles with addr 5 then 6, 1-cycle latency, ready_o stays 1.
- Backpressure: ready_i=0; push A(addr=3), B(addr=4) -> state FULL, ready_o=0 on the following cycle. Raise ready_i -> A committed, then B, in order; ready_o returns to 1 after the first pop.
- r0 suppression: push en=1, addr=0, data=0xFFFF_FFFF with ready_i=1 -> valid_o=1 and the entry pops, but wb_we_o stays 0.
- Flush collision: in state FULL with ready_i=1 and flush_i=1 -> head commits (wb_we_o=1) this cycle; next cycle valid_o=0, skid entry lost, ready_o=1.
- MEM_WB_RETIRE_CNT_EN: preload the counter to 0xFFFF_FFFF via 2^32-1 pops (or force), then one pop -> retire_cnt_o=0. A flush with 2 entries queued leaves the count unchanged.
